// File: rtl/bin_to_bcd_pkg.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_pkg
// Shared definitions for the sequential binary-to-BCD converter.
//   state_t     : converter FSM states (idle, shifting, result latch).
//   nIntDigits  : number of BCD digits that can hold any w_bin-bit value.
// Ports: none (package).
// ---------------------------------------------------------------------------
package bin_to_bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Every 3 binary bits need at most one decimal digit, so rounding
    // w_bin/3 up always leaves enough room for the full converted value.
    function automatic int nIntDigits(input int wBin);
        return (wBin + 2) / 3;
    endfunction

endpackage

// File: rtl/bcd_digit_adjust.sv
// ---------------------------------------------------------------------------
// bcd_digit_adjust
// Double-dabble correction for one BCD nibble: a digit of 5 or more gets +3
// so that the following left shift carries correctly into the next digit.
// Ports:
//   i_nibble  in   4  BCD digit before correction
//   o_nibble  out  4  corrected digit (i_nibble+3 when i_nibble >= 5)
// ---------------------------------------------------------------------------
module bcd_digit_adjust (
    input  logic [3:0] i_nibble,
    output logic [3:0] o_nibble
);

    // Inputs are at most 9 in a valid conversion, so +3 never exceeds 4 bits.
    assign o_nibble = (i_nibble >= 4'd5) ? (i_nibble + 4'd3) : i_nibble;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// bin_to_bcd_seq
// Iterative double-dabble converter, one binary bit per clock, feeding the
// seven-segment display driver. The result on number/dots is held stable
// between conversions.
// Parameters:
//   w_bin    width of the binary input
//   w_digit  BCD digits presented on number (must match the display driver)
// Ports:
//   clk        in   1            clock
//   rst        in   1            asynchronous active-high reset
//   in_valid   in   1            in_value is offered
//   in_ready   out  1            idle, accepts an input this cycle
//   in_value   in   w_bin        unsigned binary value
//   number     out  w_digit*4    packed BCD result, digit 0 in [3:0]
//   dots       out  w_digit      per-digit decimal point flags
//   out_valid  out  1            one-cycle pulse, number/dots just updated
// Build option:
//   BIN_TO_BCD_OVERFLOW_EN  when defined, all dots light if the value needs
//                           more than w_digit digits; otherwise dots stay 0
//                           and excess digits are dropped.
// ---------------------------------------------------------------------------
module bin_to_bcd_seq
    import bin_to_bcd_pkg::*;
#(
    parameter int w_bin   = 8,
    parameter int w_digit = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [w_bin-1:0]     in_value,
    output logic [w_digit*4-1:0] number,
    output logic [w_digit-1:0]   dots,
    output logic                 out_valid
);

    localparam int N_INT = nIntDigits(w_bin);
    localparam int W_SCR = N_INT * 4 + w_bin;
    localparam int W_CNT = (w_bin > 1) ? $clog2(w_bin) : 1;

    state_t               r_state;
    logic [W_CNT-1:0]     r_count;
    logic [W_SCR-1:0]     r_scratch;
    logic [w_digit*4-1:0] r_number;
    logic [w_digit-1:0]   r_dots;
    logic                 r_outValid;

    logic [N_INT*4-1:0]   w_bcdAdj;
    logic [W_SCR-1:0]     w_adjusted;
    logic [w_digit*4-1:0] w_numberNext;

    // One correction unit per BCD digit of the scratch register; all digits
    // are corrected in parallel before the shift.
    for (genvar g = 0; g < N_INT; g++) begin : gAdjust
        bcd_digit_adjust uAdjust (
            .i_nibble (r_scratch[w_bin + 4*g +: 4]),
            .o_nibble (w_bcdAdj[4*g +: 4])
        );
    end

    assign w_adjusted = {w_bcdAdj, r_scratch[w_bin-1:0]};

    // Display digits come from the low scratch digits; any display digit
    // beyond what the converter produces is forced to zero.
    for (genvar g = 0; g < w_digit; g++) begin : gNumber
        if (g < N_INT) begin : gLive
            assign w_numberNext[4*g +: 4] = r_scratch[w_bin + 4*g +: 4];
        end else begin : gPad
            assign w_numberNext[4*g +: 4] = 4'd0;
        end
    end

`ifdef BIN_TO_BCD_OVERFLOW_EN
    logic w_overflow;

    // Overflow means a nonzero digit the display cannot show.
    if (N_INT > w_digit) begin : gOverflow
        assign w_overflow = |r_scratch[W_SCR-1 : w_bin + 4*w_digit];
    end else begin : gNoOverflow
        assign w_overflow = 1'b0;
    end
`endif

    // Handshake and result flags come straight from registers, so nothing
    // on the input side reaches an output combinationally.
    assign in_ready  = (r_state == ST_IDLE);
    assign number    = r_number;
    assign dots      = r_dots;
    assign out_valid = r_outValid;

    // Converter FSM: load on acceptance, w_bin adjust-and-shift steps, then
    // one cycle to latch the result and raise out_valid. Reset aborts any
    // conversion in flight without producing a pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_scratch  <= '0;
            r_number   <= '0;
            r_dots     <= '0;
            r_outValid <= 1'b0;
        end else begin
            r_outValid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_scratch <= {{(N_INT*4){1'b0}}, in_value};
                        r_count   <= W_CNT'(w_bin - 1);
                        r_state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_scratch <= w_adjusted << 1;
                    if (r_count == '0) begin
                        r_state <= ST_DONE;
                    end else begin
                        r_count <= r_count - W_CNT'(1);
                    end
                end
                ST_DONE: begin
                    r_number <= w_numberNext;
`ifdef BIN_TO_BCD_OVERFLOW_EN
                    r_dots   <= {w_digit{w_overflow}};
`else
                    r_dots   <= '0;
`endif
                    r_outValid <= 1'b1;
                    r_state    <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// ---------------------------------------------------------------------------
// tb_bin_to_bcd_seq
// Self-checking bench for bin_to_bcd_seq: an 8-bit/2-digit instance and a
// 16-bit/5-digit instance, checked against a decimal reference model.
// Honours BIN_TO_BCD_OVERFLOW_EN for the expected dots value.
// ---------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

    logic        clk;
    logic        rst;

    logic        inValid8;
    logic        inReady8;
    logic [7:0]  inValue8;
    logic [7:0]  number8;
    logic [1:0]  dots8;
    logic        outValid8;

    logic        inValid16;
    logic        inReady16;
    logic [15:0] inValue16;
    logic [19:0] number16;
    logic [4:0]  dots16;
    logic        outValid16;

    int total = 0;
    int bad   = 0;

    logic [7:0]  lastNumber8  = '0;
    logic [19:0] lastNumber16 = '0;

    bin_to_bcd_seq #(.w_bin(8), .w_digit(2)) dut8 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid8),
        .in_ready  (inReady8),
        .in_value  (inValue8),
        .number    (number8),
        .dots      (dots8),
        .out_valid (outValid8)
    );

    bin_to_bcd_seq #(.w_bin(16), .w_digit(5)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (inValid16),
        .in_ready  (inReady16),
        .in_value  (inValue16),
        .number    (number16),
        .dots      (dots16),
        .out_valid (outValid16)
    );

    // Free-running clock: posedges at 5, 15, ...; bench works on negedges.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference: decimal digits by plain division, lowest digit first.
    function automatic logic [31:0] refBcd(input int unsigned v, input int nDigits);
        logic [31:0]  r;
        int unsigned  t;
        r = '0;
        t = v;
        for (int k = 0; k < nDigits; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Reference: dots light only when the value has more digits than shown.
    function automatic logic [31:0] refDots(input int unsigned v, input int nDigits);
        int unsigned lim;
        lim = 1;
        for (int k = 0; k < nDigits; k++) lim = lim * 10;
`ifdef BIN_TO_BCD_OVERFLOW_EN
        return (v >= lim) ? ((32'd1 << nDigits) - 32'd1) : 32'd0;
`else
        return (lim == 0) ? 32'd1 : 32'd0;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete 8-bit conversion. With wiggle set, in_valid/in_value are
    // scrambled during the shift cycles, which the DUT must ignore.
    task automatic applyStimulus(input logic [7:0] v, input bit wiggle);
        int cyc;
        inValid8 = 1'b1;
        inValue8 = v;
        checkOutput("ready_idle", 32'(inReady8), 32'd1);
        @(negedge clk);
        inValid8 = 1'b0;
        inValue8 = 8'($urandom);
        checkOutput("ready_drop", 32'(inReady8), 32'd0);
        cyc = 0;
        while (!outValid8 && cyc < 30) begin
            checkOutput("hold8", 32'(number8), 32'(lastNumber8));
            if (wiggle && cyc < 8) begin
                inValid8 = 1'($urandom);
                inValue8 = 8'($urandom);
            end else begin
                inValid8 = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        inValid8 = 1'b0;
        checkOutput("latency8", 32'(cyc), 32'd9);
        checkOutput("number8", 32'(number8), refBcd(v, 2));
        checkOutput("dots8", 32'(dots8), refDots(v, 2));
        checkOutput("ready_at_pulse", 32'(inReady8), 32'd1);
        lastNumber8 = 8'(refBcd(v, 2));
        @(negedge clk);
        checkOutput("pulse_width8", 32'(outValid8), 32'd0);
        checkOutput("stable8", 32'(number8), 32'(lastNumber8));
    endtask

    task automatic applyStimulus16(input logic [15:0] v);
        int cyc;
        inValid16 = 1'b1;
        inValue16 = v;
        checkOutput("ready16_idle", 32'(inReady16), 32'd1);
        @(negedge clk);
        inValid16 = 1'b0;
        cyc = 0;
        while (!outValid16 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("latency16", 32'(cyc), 32'd17);
        checkOutput("number16", 32'(number16), refBcd(v, 5));
        checkOutput("dots16", 32'(dots16), refDots(v, 5));
        lastNumber16 = 20'(refBcd(v, 5));
        @(negedge clk);
        checkOutput("pulse_width16", 32'(outValid16), 32'd0);
    endtask

    initial begin
        int cyc;
        int gap;
        rst       = 1'b0;
        inValid8  = 1'b0;
        inValue8  = '0;
        inValid16 = 1'b0;
        inValue16 = '0;
        #1 rst = 1'b1;

        // Reset state.
        @(negedge clk);
        checkOutput("rst_number8", 32'(number8), 32'd0);
        checkOutput("rst_dots8", 32'(dots8), 32'd0);
        checkOutput("rst_valid8", 32'(outValid8), 32'd0);
        checkOutput("rst_ready8", 32'(inReady8), 32'd1);
        checkOutput("rst_number16", 32'(number16), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Directed values, including the digit-overflow boundary.
        applyStimulus(8'd42, 1'b0);
        applyStimulus(8'd0, 1'b0);
        applyStimulus(8'd99, 1'b0);
        applyStimulus(8'd100, 1'b0);
        applyStimulus(8'd255, 1'b0);

        // Back-to-back: in_valid held high, second value taken at the pulse.
        inValid8 = 1'b1;
        inValue8 = 8'd17;
        @(negedge clk);
        inValue8 = 8'd38;
        cyc = 0;
        while (!outValid8 && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("b2b_first", 32'(number8), 32'h17);
        checkOutput("b2b_ready", 32'(inReady8), 32'd1);
        @(negedge clk);
        inValid8 = 1'b0;
        checkOutput("b2b_accepted", 32'(inReady8), 32'd0);
        gap = 1;
        while (!outValid8 && gap < 30) begin
            @(negedge clk);
            gap++;
        end
        checkOutput("b2b_gap", 32'(gap), 32'd10);
        checkOutput("b2b_second", 32'(number8), 32'h38);
        lastNumber8 = 8'h38;
        @(negedge clk);

        // Input activity during the shift phase must not disturb the result.
        applyStimulus(8'd123, 1'b1);
        applyStimulus(8'd57, 1'b1);

        // 16-bit instance, including the all-ones boundary.
        applyStimulus16(16'd65535);
        applyStimulus16(16'd0);
        applyStimulus16(16'($urandom));

        // Reset in the middle of a conversion.
        inValid8 = 1'b1;
        inValue8 = 8'd200;
        @(negedge clk);
        inValid8 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checkOutput("abort_number8", 32'(number8), 32'd0);
        checkOutput("abort_dots8", 32'(dots8), 32'd0);
        checkOutput("abort_valid8", 32'(outValid8), 32'd0);
        checkOutput("abort_ready8", 32'(inReady8), 32'd1);
        checkOutput("abort_number16", 32'(number16), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        lastNumber8 = '0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            checkOutput("abort_no_pulse", 32'(outValid8), 32'd0);
        end

        // Randomised values against the reference model.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(8'($urandom_range(0, 255)), 1'(i % 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bin_to_bcd_seq.md
# bin_to_bcd_seq

Sequential binary-to-BCD converter that feeds the seven-segment display driver. It accepts a binary value through a ready/valid handshake and converts it with an iterative double-dabble algorithm, one bit per clock. It holds the packed BCD result on `number` and `dots`, which connect directly to the display driver's `number`/`dots` inputs. The result stays stable between conversions, as the display driver's sampling requires.

## Interface
- `w_bin`, 8: width of binary input.
- `w_digit`, 2: number of BCD digits presented on `number`; must match the display driver.
- `clk`  input  1  clock.
- `rst`  input  1  reset; asynchronous, active-high.
- `in_valid`  input  1  `in_value` is offered.
- `in_ready`  output  1  block is idle and accepts an input this cycle.
- `in_value`  input  `w_bin`  unsigned binary value.
- `number`  output  `w_digit*4`  packed BCD result, digit 0 in bits [3:0].
- `dots`  output  `w_digit`  per-digit decimal point flags.
- `out_valid`  output  1  one-cycle pulse: `number`/`dots` were just updated.

## Operation
- Internal digit count: `n_int = (w_bin + 2) / 3`, which is always at least the number needed. Scratch register is `n_int*4 + w_bin` bits: BCD field above the binary field.
- States:
  - IDLE: `in_ready`=1. On `in_valid & in_ready`, scratch ← {0, `in_value`}, bit counter ← `w_bin`-1, go to SHIFT.
  - SHIFT: each cycle, every BCD nibble ≥5 gets +3 (all nibbles in parallel), then the whole scratch shifts left 1. When counter==0, go to DONE; otherwise decrement the counter.
  - DONE: `number` ← low `w_digit` BCD nibbles of scratch, `dots` ← overflow policy (see Configuration), `out_valid` ← 1 for one cycle, go to IDLE.
- `in_value` is sampled only on the acceptance edge. `in_valid` outside IDLE is ignored: no queueing and no error.
- `number`/`dots` change only on the DONE edge and otherwise hold their value.
- If `n_int` < `w_digit`, the upper `number` nibbles are 0.
- Reset values (asynchronous, immediate):
  - state IDLE, `in_ready`=1.
  - `number`=0, `dots`=0, `out_valid`=0.
  - scratch and counter 0.
- Reset mid-conversion aborts the conversion. No `out_valid` is produced for the aborted value, and the outputs go to their reset values.

## Timing
- Acceptance edge E0. Shifts occur at edges E1..E`w_bin`. The DONE edge is E`w_bin`+1.
- `out_valid` is high during the cycle after E`w_bin`+1, with the new `number` visible in the same cycle.
- Latency from acceptance to `out_valid` is `w_bin`+1 cycles (9 for defaults).
- `in_ready` is high again in the same cycle as `out_valid`. Back-to-back throughput is one conversion per `w_bin`+2 cycles.
- `in_ready` and `out_valid` are driven from registered state only; there are no combinational paths from inputs to outputs.

## Configuration
- `BIN_TO_BCD_OVERFLOW_EN`:
  - Defined: at DONE, if any scratch BCD nibble with index ≥ `w_digit` is nonzero, `dots` ← all ones; otherwise `dots` ← 0. `number` still carries the low `w_digit` digits.
  - Undefined: the overflow check is not built, `dots` stays 0, and excess digits are silently truncated.

## Structure
- Package `bin_to_bcd_pkg`:
  - state enum typedef (IDLE, SHIFT, DONE).
  - constant function returning `n_int` for a given `w_bin`.
- Sub-module `bcd_digit_adjust`: combinational, one nibble in, nibble+3 out when ≥5, instantiated `n_int` times by generate.
- Top-level module holds the FSM, bit counter, scratch and output registers.

## Test plan
- Reset, then offer `in_value`=8'd42 → `in_ready` drops the next cycle; 9 cycles after acceptance, `out_valid` pulses once with `number`=8'h42 and `dots`=2'b00.
- Offer 8'd0, then 8'd99 → `number`=8'h00, then 8'h99; `number` is stable between pulses.
- Offer 8'd255 → without macro, `number`=8'h55 and `dots`=2'b00; with `BIN_TO_BCD_OVERFLOW_EN`, `number`=8'h55 and `dots`=2'b11.
- Hold `in_valid` high with 17 and then 38 → 38 is accepted in the `out_valid` cycle of 17; results 8'h17 and 8'h38 with `out_valid` pulses 10 cycles apart.
- Change `in_value`/`in_valid` during SHIFT, then assert `rst` mid-conversion → changes are ignored; outputs go to 0 asynchronously, no pulse for the aborted value, and `in_ready`=1.
- `w_bin`=16, `w_digit`=5, `in_value`=65535 → `number`=20'h65535 after 17 cycles, `dots`=0.
